// File: rtl/pipeline_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_fetch_pkg
//  Brief    : Shared types and widths for the instruction-fetch sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package pipeline_fetch_pkg;

    // Sequencer states: one boot cycle, normal fetching, and halted.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Word delivered for ROM indices beyond the populated region.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Prefetch FIFO entry layout: {pc, instr}.
    localparam int ENTRY_PC_W    = 32;
    localparam int ENTRY_INSTR_W = 32;
    localparam int ENTRY_W       = ENTRY_PC_W + ENTRY_INSTR_W;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0]    pc;
        logic [ENTRY_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_fetch_fifo
//  Brief    : Small synchronous FIFO with push/pop/flush and occupancy count.
//             Head data is visible combinationally; flush dominates push.
//             Push while full is accepted when a pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; when full, the slot written is the one being popped this cycle.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_fetch_ctrl
//  Brief    : Instruction-fetch sequencer: owns the fetch PC, drives the ROM,
//             buffers words in a prefetch FIFO and hands them to IF/ID with a
//             valid/ready handshake. Handles redirects and halt/drain.
//             Optional macro FETCH_PERF_EN enables the perf counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_fetch_ctrl
    import pipeline_fetch_pkg::*;
#(
    parameter int          ROM_AW     = 7,
    parameter int          ROM_WORDS  = 128,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_en,
    input  logic [31:0]       rom_instr,
    input  logic              redirect_vld,
    input  logic [31:0]       redirect_pc,
    input  logic              halt_req,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic              halted,
    output logic              addr_err,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_pc;
    logic             r_addr_err;
    logic             w_fetch;
    logic             w_pop;
    logic             w_fifo_valid;
    logic             w_full;
    logic             w_in_rom;
    logic [CNT_W-1:0] w_count;
    logic [ROM_AW-1:0] w_rom_idx;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    assign w_rom_idx    = r_pc[ROM_AW+1:2];
    assign w_in_rom     = int'(w_rom_idx) < ROM_WORDS;
    assign w_fifo_valid = (w_count != '0);
    assign w_full       = (w_count == CNT_W'(FIFO_DEPTH));
    assign w_pop        = w_fifo_valid && id_ready;

    assign w_push_entry.pc    = r_pc;
    assign w_push_entry.instr = w_in_rom ? rom_instr : NOP_INSTR;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_BOOT;
        else       r_state <= w_state_nxt;
    end

    // Next state and fetch decision; a redirect never fetches and pins HALT.
    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                w_fetch = !redirect_vld && (!w_full || w_pop);
                if (halt_req) w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (!halt_req && !redirect_vld) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_BOOT;
        endcase
        if (redirect_vld && halt_req) w_state_nxt = ST_HALT;
    end

    // Fetch PC: redirect loads an aligned target; fetch advances, keeping bit 31.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= redirect_vld && (redirect_pc[1:0] != 2'b00);
            if (redirect_vld) r_pc <= {redirect_pc[31:2], 2'b00};
            else if (w_fetch) r_pc <= {r_pc[31], r_pc[30:0] + 31'd4};
        end
    end

    pipeline_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_flush (redirect_vld),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign rom_addr = w_rom_idx;
    assign rom_en   = w_fetch;
    assign if_valid = w_fifo_valid;
    assign if_instr = w_fifo_valid ? w_head.instr : 32'h0;
    assign if_pc    = w_fifo_valid ? w_head.pc    : 32'h0;
    assign halted   = (r_state == ST_HALT) && !w_fifo_valid;
    assign addr_err = r_addr_err;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Event counters: fetches, full-and-blocked RUN cycles, redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch <= 32'd0;
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            if (w_fetch) r_perf_fetch <= r_perf_fetch + 32'd1;
            if ((r_state == ST_RUN) && w_full && !w_pop) r_perf_stall <= r_perf_stall + 32'd1;
            if (redirect_vld) r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;
`else
    assign perf_fetch = 32'd0;
    assign perf_stall = 32'd0;
    assign perf_flush = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_fetch_ctrl
//  Brief    : Self-checking bench for pipeline_fetch_ctrl with a queue-based
//             reference model of the fetch sequencer and prefetch buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_fetch_ctrl;

    localparam int          ROM_AW     = 7;
    localparam int          ROM_WORDS  = 100;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam int          S_BOOT = 0, S_RUN = 1, S_HALT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_en;
    logic [31:0]       rom_instr;
    logic              redirect_vld;
    logic [31:0]       redirect_pc;
    logic              halt_req;
    logic              id_ready;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic              halted;
    logic              addr_err;
    logic [31:0]       perf_fetch, perf_stall, perf_flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int idx);
        return 32'h0F00_0013 ^ (32'(idx) * 32'h0101_0100);
    endfunction

    assign rom_instr = rom_word(int'(rom_addr));

    pipeline_fetch_ctrl #(
        .ROM_AW(ROM_AW), .ROM_WORDS(ROM_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_en(rom_en), .rom_instr(rom_instr),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .halted(halted), .addr_err(addr_err), .perf_fetch(perf_fetch),
        .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    // ---------------- reference model ----------------
    int          m_state;
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    logic        m_addr_err;
    logic [31:0] m_pf, m_ps, m_pl;
    bit          m_pop_t, m_fet_t;

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        int idx = int'(pc[ROM_AW+1:2]);
        return (idx < ROM_WORDS) ? rom_word(idx) : 32'h0;
    endfunction

    function automatic bit exp_fetch();
        bit pop = (m_q.size() > 0) && id_ready;
        return (m_state == S_RUN) && !redirect_vld && ((m_q.size() < FIFO_DEPTH) || pop);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_state = S_BOOT; m_pc = RESET_PC; m_q.delete(); m_addr_err = 1'b0;
            m_pf = 0; m_ps = 0; m_pl = 0;
        end else begin
            m_pop_t = (m_q.size() > 0) && id_ready;
            m_fet_t = exp_fetch();
`ifdef FETCH_PERF_EN
            if (m_fet_t) m_pf = m_pf + 1;
            if (m_state == S_RUN && m_q.size() == FIFO_DEPTH && !m_pop_t) m_ps = m_ps + 1;
            if (redirect_vld) m_pl = m_pl + 1;
`endif
            if (m_pop_t) void'(m_q.pop_front());
            if (redirect_vld) begin
                m_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (m_fet_t) begin
                m_q.push_back({m_pc, exp_word(m_pc)});
                m_pc = {m_pc[31], m_pc[30:0] + 31'd4};
            end
            m_addr_err = redirect_vld && (redirect_pc[1:0] != 2'b00);
            if (redirect_vld && (halt_req || m_state == S_HALT)) m_state = S_HALT;
            else if (m_state == S_BOOT) m_state = S_RUN;
            else m_state = halt_req ? S_HALT : S_RUN;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; redirect_vld = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; id_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid act=%b exp=0", if_valid); end
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en act=%b exp=0", rom_en); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted act=%b exp=0", halted); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err act=%b exp=0", addr_err); end
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_data act=%h/%h exp=0/0", if_pc, if_instr); end
        checks++; if ({perf_fetch, perf_stall, perf_flush} !== 96'h0) begin errors++; $display("FAIL reset_perf act=%h %h %h exp=0", perf_fetch, perf_stall, perf_flush); end
    endtask

    task automatic test_stream();
        @(negedge clk); reset = 1'b0; id_ready = 1'b1; #1;
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL boot_rom_en act=%b exp=0", rom_en); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            checks++; if (rom_en !== 1'b1 || rom_addr !== 7'(k)) begin errors++; $display("FAIL stream_rom k=%0d act=%b/%h exp=1/%h", k, rom_en, rom_addr, k); end
            checks++; if (if_valid !== (k >= 1)) begin errors++; $display("FAIL stream_valid k=%0d act=%b exp=%b", k, if_valid, (k >= 1)); end
            if (k >= 1) begin
                checks++; if (if_pc !== RESET_PC + 32'(4 * (k - 1)) || if_instr !== rom_word(k - 1)) begin
                    errors++; $display("FAIL stream_word k=%0d act=%h/%h exp=%h/%h", k, if_pc, if_instr, RESET_PC + 32'(4 * (k - 1)), rom_word(k - 1));
                end
            end
        end
    endtask

    task automatic test_stall_and_full_pop();
        logic [31:0] exp_pc [5] = '{32'h80000040, 32'h80000044, 32'h80000044, 32'h80000048, 32'h8000004C};
        bit          rdy    [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        bit          en     [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int nfetch = 0;
        logic [31:0] stall0;
        @(negedge clk); redirect_vld = 1'b1; redirect_pc = 32'h80000040; id_ready = 1'b0; #1;
        stall0 = perf_stall;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); redirect_vld = 1'b0; #1;
            nfetch += int'(rom_en);
            if (c == 5) begin
                checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL stall_rom_en act=%b exp=0", rom_en); end
            end
        end
        checks++; if (nfetch != FIFO_DEPTH) begin errors++; $display("FAIL stall_fetches act=%0d exp=%0d", nfetch, FIFO_DEPTH); end
        for (int r = 0; r < 5; r++) begin
            @(negedge clk); id_ready = rdy[r]; #1;
`ifdef FETCH_PERF_EN
            if (r == 0) begin
                checks++; if (perf_stall - stall0 !== 32'd4) begin errors++; $display("FAIL stall_perf act=%0d exp=4", perf_stall - stall0); end
            end
`endif
            checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc[r]) begin errors++; $display("FAIL order r=%0d act=%b/%h exp=1/%h", r, if_valid, if_pc, exp_pc[r]); end
            checks++; if (rom_en !== en[r]) begin errors++; $display("FAIL fullpop_rom_en r=%0d act=%b exp=%b", r, rom_en, en[r]); end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] flush0;
        repeat (2) begin @(negedge clk); id_ready = 1'b0; end
        @(negedge clk); redirect_vld = 1'b1; redirect_pc = 32'h80000134; #1;
        flush0 = perf_flush;
        @(negedge clk); redirect_vld = 1'b0; #1;
        checks++; if (if_valid !== 1'b0 || rom_addr !== 7'h4D || rom_en !== 1'b1) begin
            errors++; $display("FAIL redirect_fetch act=%b/%h/%b exp=0/4d/1", if_valid, rom_addr, rom_en);
        end
`ifdef FETCH_PERF_EN
        checks++; if (perf_flush - flush0 !== 32'd1) begin errors++; $display("FAIL redirect_perf act=%0d exp=1", perf_flush - flush0); end
`endif
        @(negedge clk); id_ready = 1'b1; #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h80000134 || if_instr !== rom_word(32'h4D)) begin
            errors++; $display("FAIL redirect_word act=%b/%h/%h exp=1/80000134/%h", if_valid, if_pc, if_instr, rom_word(32'h4D));
        end
    endtask

    task automatic test_addr_err();
        @(negedge clk); redirect_vld = 1'b1; redirect_pc = 32'h8000000A; #1;
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_early act=%b exp=0", addr_err); end
        @(negedge clk); redirect_vld = 1'b0; #1;
        checks++; if (addr_err !== 1'b1 || rom_addr !== 7'd2) begin errors++; $display("FAIL addr_err_pulse act=%b/%h exp=1/02", addr_err, rom_addr); end
        @(negedge clk); #1;
        checks++; if (addr_err !== 1'b0 || if_pc !== 32'h80000008) begin errors++; $display("FAIL addr_err_end act=%b/%h exp=0/80000008", addr_err, if_pc); end
    endtask

    task automatic test_rom_boundary();
        logic [31:0] tgt [2] = '{32'h8000018C, 32'hFFFFFFFC};
        logic [31:0] p2  [2] = '{32'h80000190, 32'h80000000};
        logic [31:0] i1  [2] = '{rom_word(99), 32'h0};
        logic [31:0] i2  [2] = '{32'h0, rom_word(0)};
        for (int t = 0; t < 2; t++) begin
            @(negedge clk); redirect_vld = 1'b1; redirect_pc = tgt[t]; id_ready = 1'b1;
            @(negedge clk); redirect_vld = 1'b0;
            @(negedge clk); #1;
            checks++; if (if_pc !== tgt[t] || if_instr !== i1[t]) begin errors++; $display("FAIL bound_first t=%0d act=%h/%h exp=%h/%h", t, if_pc, if_instr, tgt[t], i1[t]); end
            @(negedge clk); #1;
            checks++; if (if_valid !== 1'b1 || if_pc !== p2[t] || if_instr !== i2[t]) begin errors++; $display("FAIL bound_next t=%0d act=%b/%h/%h exp=1/%h/%h", t, if_valid, if_pc, if_instr, p2[t], i2[t]); end
        end
    endtask

    task automatic test_halt_and_reset();
        @(negedge clk); halt_req = 1'b1; id_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (rom_en !== 1'b0 || if_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_drain act=%b/%b/%b exp=0/0/1", rom_en, if_valid, halted); end
        @(negedge clk); halt_req = 1'b0; id_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (rom_en !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL halt_resume act=%b/%b exp=1/0", rom_en, halted); end
        @(negedge clk); #1;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL halt_one_word act=%b exp=1", if_valid); end
        reset = 1'b1;
        @(negedge clk); #1;
        checks++; if (if_valid !== 1'b0 || rom_en !== 1'b0) begin errors++; $display("FAIL reset_discard act=%b/%b exp=0/0", if_valid, rom_en); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] e_pc, e_ins;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            reset        = ($urandom_range(0, 199) == 0);
            id_ready     = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
            redirect_vld = ($urandom_range(0, 7) == 0);
            redirect_pc  = {($urandom_range(0, 3) != 0), 31'(($urandom_range(0, 3) == 0) ? 32'h7FFFFFF8 : 32'($urandom_range(0, 130) * 4))};
            if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            #1;
            e_pc  = (m_q.size() > 0) ? m_q[0][63:32] : 32'h0;
            e_ins = (m_q.size() > 0) ? m_q[0][31:0]  : 32'h0;
            checks++; if (if_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d act=%b exp=%b", c, if_valid, (m_q.size() > 0)); end
            checks++; if (if_pc !== e_pc || if_instr !== e_ins) begin errors++; $display("FAIL rnd_word c=%0d act=%h/%h exp=%h/%h", c, if_pc, if_instr, e_pc, e_ins); end
            checks++; if (rom_en !== exp_fetch()) begin errors++; $display("FAIL rnd_rom_en c=%0d act=%b exp=%b", c, rom_en, exp_fetch()); end
            checks++; if (rom_addr !== m_pc[ROM_AW+1:2]) begin errors++; $display("FAIL rnd_rom_addr c=%0d act=%h exp=%h", c, rom_addr, m_pc[ROM_AW+1:2]); end
            checks++; if (halted !== (m_state == S_HALT && m_q.size() == 0)) begin errors++; $display("FAIL rnd_halted c=%0d act=%b", c, halted); end
            checks++; if (addr_err !== m_addr_err) begin errors++; $display("FAIL rnd_addr_err c=%0d act=%b exp=%b", c, addr_err, m_addr_err); end
            checks++; if (perf_fetch !== m_pf || perf_stall !== m_ps || perf_flush !== m_pl) begin
                errors++; $display("FAIL rnd_perf c=%0d act=%0d/%0d/%0d exp=%0d/%0d/%0d", c, perf_fetch, perf_stall, perf_flush, m_pf, m_ps, m_pl);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall_and_full_pop();
        test_redirect();
        test_addr_err();
        test_rom_boundary();
        test_halt_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
